// File: rtl/router_ctrl_fsm.sv
// Router control FSM: decodes packet headers, sequences payload/parity
// loading into the addressed FIFO and handles full stalls and soft resets.
module router_ctrl_fsm #(
    parameter bit SOFT_RST_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic       fifo_full,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [1:0] addr_reg
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t state, next;
    logic   hdr_ok, empty_din, empty_addr, soft_addr;

    always_comb begin
        hdr_ok = pkt_valid && (din != 2'd3);

        empty_din = 1'b0;
        case (din)
            2'd0:    empty_din = empty_0;
            2'd1:    empty_din = empty_1;
            2'd2:    empty_din = empty_2;
            default: empty_din = 1'b0;
        endcase

        empty_addr = 1'b0;
        soft_addr  = 1'b0;
        case (addr_reg)
            2'd0: begin empty_addr = empty_0; soft_addr = soft_reset_0; end
            2'd1: begin empty_addr = empty_1; soft_addr = soft_reset_1; end
            2'd2: begin empty_addr = empty_2; soft_addr = soft_reset_2; end
            default: begin empty_addr = 1'b0; soft_addr = 1'b0; end
        endcase
    end

    always_comb begin
        next = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS:
                if (hdr_ok) next = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else        next = DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                next = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                next = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)       next = FIFO_FULL_STATE;
                else if (!pkt_valid) next = LOAD_PARITY;
                else                 next = LOAD_DATA;
            FIFO_FULL_STATE:
                next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)        next = DECODE_ADDRESS;
                else if (low_pkt_valid) next = LOAD_PARITY;
                else                    next = LOAD_DATA;
            LOAD_PARITY:
                next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
                next = DECODE_ADDRESS;
        endcase
        if (SOFT_RST_EN && soft_addr)
            next = DECODE_ADDRESS;
    end

    // Outputs are registered from the next-state decode so they always
    // match the current state, with no input-to-output paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DECODE_ADDRESS;
            addr_reg      <= '0;
            detect_addr   <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_reg <= din;
            detect_addr   <= (next == DECODE_ADDRESS);
            lfd_state     <= (next == LOAD_FIRST_DATA);
            ld_state      <= (next == LOAD_DATA);
            laf_state     <= (next == LOAD_AFTER_FULL);
            full_state    <= (next == FIFO_FULL_STATE);
            rst_int_reg   <= (next == CHECK_PARITY_ERROR);
            write_enb_reg <= (next == LOAD_DATA) || (next == LOAD_PARITY) ||
                             (next == LOAD_AFTER_FULL);
            busy          <= !((next == DECODE_ADDRESS) || (next == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: table-driven cycle vectors plus
// hand sequences for async reset and the soft-reset-disabled variant.
module tb_router_ctrl_fsm;

    // Output vector order: {detect, lfd, ld, full, laf, rst_int, wen, busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0010;
    localparam logic [7:0] O_FUL = 8'b0001_0001;
    localparam logic [7:0] O_LAF = 8'b0000_1011;
    localparam logic [7:0] O_LP  = 8'b0000_0011;
    localparam logic [7:0] O_CPE = 8'b0000_0101;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] empty;
        logic [2:0] srst;
        logic       pdone;
        logic       lpv;
        logic [7:0] exp_out;
        logic [1:0] exp_addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] din;
    logic [2:0] empty, srst;

    logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [1:0] addr_reg;
    logic       n_detect, n_lfd, n_ld, n_laf, n_full, n_wen, n_rst_int, n_busy;
    logic [1:0] n_addr;
    logic [7:0] outs, n_outs;

    int unsigned tests = 0;
    int unsigned fails = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    router_ctrl_fsm #(.SOFT_RST_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
        .fifo_full(fifo_full), .empty_0(empty[0]), .empty_1(empty[1]),
        .empty_2(empty[2]), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]),
        .soft_reset_2(srst[2]), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .detect_addr(detect_addr),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .addr_reg(addr_reg)
    );

    router_ctrl_fsm #(.SOFT_RST_EN(1'b0)) dut_nosr (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
        .fifo_full(fifo_full), .empty_0(empty[0]), .empty_1(empty[1]),
        .empty_2(empty[2]), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]),
        .soft_reset_2(srst[2]), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .detect_addr(n_detect),
        .lfd_state(n_lfd), .ld_state(n_ld), .laf_state(n_laf),
        .full_state(n_full), .write_enb_reg(n_wen),
        .rst_int_reg(n_rst_int), .busy(n_busy), .addr_reg(n_addr)
    );

    assign outs   = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                     rst_int_reg, write_enb_reg, busy};
    assign n_outs = {n_detect, n_lfd, n_ld, n_full, n_laf, n_rst_int, n_wen, n_busy};

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [1:0] d, input logic ff,
                       input logic [2:0] e, input logic [2:0] s, input logic pd,
                       input logic lp, input logic [7:0] eo, input logic [1:0] ea);
        vec_t v;
        v.pv = pv; v.din = d; v.ff = ff; v.empty = e; v.srst = s;
        v.pdone = pd; v.lpv = lp; v.exp_out = eo; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [1:0] d, input logic [2:0] s);
        pkt_valid = pv; din = d; srst = s;
        fifo_full = 1'b0; empty = 3'b111; parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    initial begin
        // Each row: inputs during a cycle, expected outputs after its clock edge.
        //   pv din  ff empty   srst   pd lp  exp    addr
        add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD, 2'd1); // 0  basic packet header
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd1); // 1  addr holds outside decode
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd1);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd1);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd1); // 4  fourth LD
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP,  2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE, 2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA,  2'd1);
        add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DA,  2'd1); // 8  invalid header dropped
        add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE, 2'd2); // 9  busy FIFO 2
        add(0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE, 2'd2); // 10 waits on addr_reg, not din
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd2); // 12
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL, 2'd2); // 13 full stall x3
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL, 2'd2);
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd2); // 17
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP,  2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE, 2'd2);
        add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL, 2'd2); // 20 CPE with full
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP,  2'd2); // 22 low_pkt_valid
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA,  2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD, 2'd0); // 25
        add(1, 2'd0, 0, 3'b111, 3'b100, 0, 0, O_LD,  2'd0); // 26 other FIFO soft reset ignored
        add(1, 2'd0, 0, 3'b111, 3'b100, 0, 0, O_LD,  2'd0);
        add(1, 2'd0, 0, 3'b111, 3'b001, 0, 0, O_DA,  2'd0); // 28 soft reset abort
        add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD, 2'd1);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,  2'd1);
        add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL, 2'd1); // 31 full beats pv=0
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF, 2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 1, 1, O_DA,  2'd1); // 33 parity_done priority
        add(1, 2'd0, 0, 3'b110, 3'b000, 0, 0, O_WTE, 2'd0);
        add(0, 2'd0, 0, 3'b110, 3'b001, 0, 0, O_DA,  2'd0); // 35 soft reset from WTE
        add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_DA,  2'd0); // 36 no pkt_valid

        drive(1'b0, 2'd0, 3'b000);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_out_async", outs, O_DA);
        check("reset_addr", {6'd0, addr_reg}, 8'd0);
        step();
        step();
        rst = 1'b0;
        check("reset_hold", outs, O_DA);

        for (int i = 0; i < vecs.size(); i++) begin
            pkt_valid     = vecs[i].pv;
            din           = vecs[i].din;
            fifo_full     = vecs[i].ff;
            empty         = vecs[i].empty;
            srst          = vecs[i].srst;
            parity_done   = vecs[i].pdone;
            low_pkt_valid = vecs[i].lpv;
            step();
            check($sformatf("v%0d_out", i), outs, vecs[i].exp_out);
            check($sformatf("v%0d_addr", i), {6'd0, addr_reg}, {6'd0, vecs[i].exp_addr});
        end

        // Async reset mid-LOAD_DATA, between clock edges
        drive(1'b1, 2'd1, 3'b000);
        step();
        check("ar_lfd", outs, O_LFD);
        step();
        check("ar_ld", outs, O_LD);
        #2 rst = 1'b1;
        #1;
        check("ar_async_out", outs, O_DA);
        check("ar_async_addr", {6'd0, addr_reg}, 8'd0);
        @(posedge clk);
        #1;
        check("ar_held", outs, O_DA);
        rst = 1'b0;
        drive(1'b1, 2'd2, 3'b000);
        step();
        check("ar_post_lfd", outs, O_LFD);
        check("ar_post_addr", {6'd0, addr_reg}, 8'd2);

        // SOFT_RST_EN=0 instance must ignore soft resets of the addressed FIFO
        check("nosr_lfd", n_outs, O_LFD);
        drive(1'b1, 2'd0, 3'b100);
        step();
        check("sr_abort", outs, O_DA);
        check("nosr_ignore", n_outs, O_LD);
        drive(1'b1, 2'd0, 3'b100);
        step();
        check("nosr_stay", n_outs, O_LD);
        check("nosr_addr", {6'd0, n_addr}, 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
